// File: rtl/mcycle_seq_pkg.sv
// rtl/mcycle_seq_pkg.sv - shared state encoding and defaults for the multi-cycle sequencer
package mcycle_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } mcycle_state_t;

  localparam int unsigned MCYCLE_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/mcycle_sequencer_if.sv
// rtl/mcycle_sequencer_if.sv - pipeline-side handshake bundle for the multi-cycle sequencer
interface mcycle_sequencer_if;

  logic Req;
  logic OpIn;
  logic done;
  logic M_Start;
  logic MCycleOp;
  logic Stall;
  logic MWrite;
  logic Err;

  modport master (
    output Req, OpIn, done,
    input  M_Start, MCycleOp, Stall, MWrite, Err
  );

  modport slave (
    input  Req, OpIn, done,
    output M_Start, MCycleOp, Stall, MWrite, Err
  );

endinterface

// File: rtl/mcycle_watchdog.sv
// rtl/mcycle_watchdog.sv - WAIT-cycle counter that flags an abort after TIMEOUT_CYCLES idle waits
module mcycle_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_expire
);

  localparam logic [7:0] LIMIT_M1 = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_tick) begin
      r_count <= r_count + 8'd1;
    end
  end

  // Expires on the tick that would bring the count to the limit; a done in
  // that cycle suppresses the tick, so done wins the race.
  assign o_expire = i_tick && (r_count == LIMIT_M1);

endmodule

// File: rtl/mcycle_sequencer.sv
// rtl/mcycle_sequencer.sv - IDLE/ISSUE/WAIT/WB sequencer for MUL/DIV; optional timeout via MCYCLE_TIMEOUT_EN
module mcycle_sequencer
  import mcycle_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = MCYCLE_TIMEOUT_DEFAULT
) (
  input logic                CLK,
  input logic                rst,
  mcycle_sequencer_if.slave  io_bus
);

  mcycle_state_t r_state;
  mcycle_state_t w_next_state;
  logic          r_op;
  logic          w_accept;
  logic          w_expire;

`ifdef MCYCLE_TIMEOUT_EN
  logic r_err;

  mcycle_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk    (CLK),
    .i_rst    (rst),
    .i_clear  (r_state == ST_ISSUE),
    .i_tick   ((r_state == ST_WAIT) && !io_bus.done),
    .o_expire (w_expire)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_expire) begin
      r_err <= 1'b1;
    end
  end

  assign io_bus.Err = r_err;
`else
  logic [7:0] w_unused_timeout;

  assign w_unused_timeout = 8'(TIMEOUT_CYCLES);
  assign w_expire         = 1'b0;
  assign io_bus.Err       = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_op <= io_bus.OpIn;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (io_bus.Req) begin
          w_next_state = ST_ISSUE;
          w_accept     = 1'b1;
        end
      end
      ST_ISSUE: w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (io_bus.done) begin
          w_next_state = ST_WB;
        end else if (w_expire) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WB:   w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Strobes are masked while rst is high so an aborted op never starts or writes back.
  assign io_bus.M_Start  = (r_state == ST_ISSUE) && !rst;
  assign io_bus.MWrite   = (r_state == ST_WB) && !rst;
  assign io_bus.MCycleOp = r_op;
  assign io_bus.Stall    = ((r_state == ST_IDLE) && io_bus.Req) ||
                           (r_state == ST_ISSUE) || (r_state == ST_WAIT);

endmodule
